// File: rtl/router_source.sv
// Frame transmitter for one router lane: buffers a payload, sends header + payload,
// and replays the whole frame after a collision until the retry budget runs out.
module router_source #(
  parameter int         MaxLen     = 256,
  parameter logic [7:0] SrcId      = 8'h00,
  parameter int         Backoff    = 4,
  parameter int         MaxRetries = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  REQ_DEST,
  input  logic [15:0] REQ_LEN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [63:0] PD,
  input  logic        PD_VALID,
  output logic        PD_READY,
  output logic [63:0] D,
  output logic        D_VALID,
  input  logic        D_BP,
  input  logic        COLLISION,
  output logic        SENT,
  output logic        DROP,
  output logic        ERR_LEN,
  output logic        BUSY,
  output logic [2:0]  DBG_STATE
);

  localparam int AW = $clog2(MaxLen);
  localparam int RW = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  localparam int BW = $clog2(Backoff + 1);
  localparam logic [RW-1:0] MAX_RETRY = RW'(MaxRetries);
  localparam logic [BW-1:0] BOFF_LAST = BW'(Backoff);
  localparam logic [15:0]   MAX_LEN16 = 16'(MaxLen);

  // Handshakes: a transfer happens on a posedge where valid and ready are both high;
  // the lane side has no ready, a word with D_VALID=1 is always absorbed by the router.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND    = 3'd2,
    FIN     = 3'd3,
    BACKOFF = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    dest_q, dest_d;
  logic [15:0]   len_q, len_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [BW-1:0] boff_q, boff_d;
  logic [63:0]   d_q, d_d;
  logic          d_valid_q, d_valid_d;
  logic          req_ready_q, req_ready_d;
  logic          pd_ready_q, pd_ready_d;
  logic          sent_q, sent_d;
  logic          drop_q, drop_d;
  logic          err_len_q, err_len_d;
  logic          busy_q, busy_d;
  logic [63:0]   mem_q [MaxLen];

  logic          mem_we, issue, collide;
  logic [AW:0]   cur_ptr;
  logic [AW-1:0] rd_addr;

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wptr_q] <= PD;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      len_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      retry_q     <= '0;
      boff_q      <= '0;
      d_q         <= '0;
      d_valid_q   <= 1'b0;
      req_ready_q <= 1'b0;
      pd_ready_q  <= 1'b0;
      sent_q      <= 1'b0;
      drop_q      <= 1'b0;
      err_len_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      retry_q     <= retry_d;
      boff_q      <= boff_d;
      d_q         <= d_d;
      d_valid_q   <= d_valid_d;
      req_ready_q <= req_ready_d;
      pd_ready_q  <= pd_ready_d;
      sent_q      <= sent_d;
      drop_q      <= drop_d;
      err_len_q   <= err_len_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    len_d       = len_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    retry_d     = retry_q;
    boff_d      = boff_q;
    d_d         = d_q;
    d_valid_d   = 1'b0;
    req_ready_d = req_ready_q;
    pd_ready_d  = pd_ready_q;
    sent_d      = 1'b0;
    drop_d      = 1'b0;
    err_len_d   = 1'b0;
    mem_we      = 1'b0;
    issue       = 1'b0;
    collide     = 1'b0;
    cur_ptr     = '0;
    rd_addr     = '0;
    busy_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (REQ_VALID && req_ready_q) begin
          dest_d  = REQ_DEST;
          len_d   = REQ_LEN;
          retry_d = '0;
          if (REQ_LEN == 16'd0 || REQ_LEN > MAX_LEN16) begin
            err_len_d = 1'b1;
          end else begin
            state_d     = LOAD;
            req_ready_d = 1'b0;
            pd_ready_d  = 1'b1;
            wptr_d      = '0;
          end
        end
      end
      LOAD: begin
        if (PD_VALID && pd_ready_q) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          // The header goes out on the same edge that stores the last payload word.
          if (16'(wptr_q) == len_q - 16'd1) begin
            pd_ready_d = 1'b0;
            rptr_d     = '0;
            state_d    = SEND;
            issue      = 1'b1;
          end
        end
      end
      SEND: begin
        if (COLLISION) collide = 1'b1;
        else           issue   = 1'b1;
      end
      FIN: begin
        if (COLLISION) begin
          collide = 1'b1;
        end else begin
          sent_d      = 1'b1;
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end
      BACKOFF: begin
        // Counts 0..Backoff so the lost slot plus Backoff quiet cycles precede the replay.
        if (boff_q == BOFF_LAST) begin
          rptr_d  = '0;
          state_d = SEND;
          issue   = 1'b1;
        end else begin
          boff_d = boff_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (collide) begin
      if (retry_q < MAX_RETRY) begin
        retry_d = retry_q + 1'b1;
        rptr_d  = '0;
        boff_d  = '0;
        state_d = BACKOFF;
      end else begin
        drop_d      = 1'b1;
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    end

    // Read pointer 0 is the header; pointer k>0 maps to buffer[k-1].
    cur_ptr = rptr_d;
    rd_addr = AW'(cur_ptr - 1'b1);
    if (issue && !D_BP) begin
      d_valid_d = 1'b1;
      d_d       = (cur_ptr == '0) ? {32'd0, len_q, SrcId, dest_q} : mem_q[rd_addr];
      rptr_d    = cur_ptr + 1'b1;
      if (16'(cur_ptr) == len_q) state_d = FIN;
    end

    busy_d = (state_d != IDLE);
  end

  assign REQ_READY = req_ready_q;
  assign PD_READY  = pd_ready_q;
  assign D         = d_q;
  assign D_VALID   = d_valid_q;
  assign SENT      = sent_q;
  assign DROP      = drop_q;
  assign ERR_LEN   = err_len_q;
  assign BUSY      = busy_q;
  assign DBG_STATE = state_q;

endmodule
